// File: rtl/quant_pkg.sv
// Shared types and default constants for the int8 quantization scheduler.
package quant_pkg;

    localparam int unsigned LEN_W_DEF      = 16;
    localparam int unsigned PACK_DEF       = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    // Unity reciprocal scale in Q8.24.
    localparam logic [31:0] Q824_ONE = 32'h0100_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage, pointers and count; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/quant_scheduler.sv
// Streams int32 accumulators through an external fixed-latency quantizer and
// packs the int8 results into output words, with credit-based flow control.
module quant_scheduler
    import quant_pkg::*;
#(
    parameter int unsigned LEN_W      = LEN_W_DEF,
    parameter int unsigned PACK       = PACK_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_W-1:0]    length,
    input  logic [31:0]         scale,
    input  logic [LEN_W-1:0]    src_base,
    input  logic [LEN_W-1:0]    dst_base,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                acc_rd_en,
    output logic [LEN_W-1:0]    acc_rd_addr,
    input  logic [31:0]         acc_rd_data,
    output logic [31:0]         q_value,
    output logic [31:0]         q_scale,
    output logic                q_valid_in,
    input  logic signed [7:0]   q_result,
    input  logic                q_valid_out,
    output logic                out_wr_en,
    output logic [LEN_W-1:0]    out_wr_addr,
    output logic [8*PACK-1:0]   out_wr_data,
    input  logic                out_wr_ready
);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned WORD_W = 8 * PACK;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   src_q;
    logic [LEN_W-1:0]   dst_q;
    logic [31:0]        scale_q;
    logic [LEN_W-1:0]   rd_cnt;
    logic [LEN_W-1:0]   pop_cnt;
    logic [LEN_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [LANE_W-1:0]  lane;
    logic [WORD_W-1:0]  pack_buf;
    logic [WORD_W-1:0]  word_c;
    logic [7:0]         fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic               accept_c;
    logic               issue_c;
    logic               credit_ok_c;
    logic               res_c;
    logic               push_c;
    logic               pop_c;
    logic               emit_c;
    logic               last_pop_c;
    logic               wr_accept_c;

    // Quantizer operands: data arrives one cycle after the read, aligned with q_valid_in.
    assign q_value = acc_rd_data;
    assign q_scale = scale_q;

    assign credit_ok_c = (SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);
    assign res_c       = q_valid_out && (inflight != '0);
    assign push_c      = res_c && !fifo_full;
    assign wr_accept_c = out_wr_en && out_wr_ready;
    assign pop_c       = !fifo_empty && (!out_wr_en || out_wr_ready);
    assign last_pop_c  = pop_c && (pop_cnt == len_q - LEN_W'(1));
    assign emit_c      = pop_c && ((lane == LANE_W'(PACK - 1)) || last_pop_c);

    // Popped byte merged into its lane of the word under construction.
    always_comb begin
        word_c                    = pack_buf;
        word_c[{lane, 3'b000} +: 8] = fifo_dout;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .din   (q_result),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (length == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_cnt == len_q) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((inflight == '0) && fifo_empty && (pop_cnt == len_q) &&
                    (!out_wr_en || out_wr_ready)) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM decode: job acceptance and read issue under the in-flight credit limit.
    always_comb begin
        accept_c = 1'b0;
        issue_c  = 1'b0;
        case (state)
            ST_IDLE: accept_c = start;
            ST_RUN:  issue_c  = (rd_cnt != len_q) && credit_ok_c;
            default: begin
                accept_c = 1'b0;
                issue_c  = 1'b0;
            end
        endcase
    end

    // Job registers, status, read side and credit tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            scale_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rd_cnt      <= '0;
            inflight    <= '0;
            acc_rd_en   <= 1'b0;
            acc_rd_addr <= '0;
            q_valid_in  <= 1'b0;
        end else begin
            busy       <= (state_nxt != ST_IDLE);
            done       <= (state_nxt == ST_FINISH);
            acc_rd_en  <= issue_c;
            q_valid_in <= acc_rd_en;
            inflight   <= inflight + CNT_W'(issue_c) - CNT_W'(res_c);
            if (accept_c) begin
                len_q   <= length;
                src_q   <= src_base;
                dst_q   <= dst_base;
                scale_q <= scale;
                rd_cnt  <= '0;
                err     <= 1'b0;
            end
            if (issue_c) begin
                acc_rd_addr <= src_q + rd_cnt;
                rd_cnt      <= rd_cnt + LEN_W'(1);
            end
            if (q_valid_out && (inflight == '0)) begin
                err <= 1'b1;
            end
        end
    end

    // Packer and output write port; the pending word holds until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_cnt     <= '0;
            word_cnt    <= '0;
            lane        <= '0;
            pack_buf    <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
        end else begin
            if (wr_accept_c) begin
                out_wr_en <= 1'b0;
            end
            if (accept_c) begin
                pop_cnt  <= '0;
                word_cnt <= '0;
                lane     <= '0;
                pack_buf <= '0;
            end else if (pop_c) begin
                pop_cnt <= pop_cnt + LEN_W'(1);
                if (emit_c) begin
                    out_wr_en   <= 1'b1;
                    out_wr_data <= word_c;
                    out_wr_addr <= dst_q + word_cnt;
                    word_cnt    <= word_cnt + LEN_W'(1);
                    lane        <= '0;
                    pack_buf    <= '0;
                end else begin
                    lane     <= lane + LANE_W'(1);
                    pack_buf <= word_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_quant_scheduler.sv
// Directed bench for quant_scheduler with a 3-stage saturating quantizer model.
module tb_quant_scheduler;
    import quant_pkg::*;

    localparam int unsigned LEN_W = 16;
    localparam int unsigned PACK  = 4;
    localparam int unsigned DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  length = '0;
    logic [31:0]       scale = '0;
    logic [LEN_W-1:0]  src_base = '0;
    logic [LEN_W-1:0]  dst_base = '0;
    logic              busy, done, err;
    logic              acc_rd_en;
    logic [LEN_W-1:0]  acc_rd_addr;
    logic [31:0]       acc_rd_data;
    logic [31:0]       q_value, q_scale;
    logic              q_valid_in;
    logic [7:0]        q_result;
    logic              q_valid_out;
    logic              out_wr_en;
    logic [LEN_W-1:0]  out_wr_addr;
    logic [31:0]       out_wr_data;
    logic              out_wr_ready = 1'b1;
    logic              inj = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_total = 0;
    logic [LEN_W-1:0] wr_addr_q [$];
    logic [31:0]      wr_data_q [$];
    int               wr_cyc_q  [$];

    logic [31:0] mem [256];
    logic [2:0]  v_pipe;
    logic [7:0]  r_pipe [3];

    always #5 clk = ~clk;

    quant_scheduler #(.LEN_W(LEN_W), .PACK(PACK), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .length       (length),
        .scale        (scale),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .acc_rd_en    (acc_rd_en),
        .acc_rd_addr  (acc_rd_addr),
        .acc_rd_data  (acc_rd_data),
        .q_value      (q_value),
        .q_scale      (q_scale),
        .q_valid_in   (q_valid_in),
        .q_result     (q_result),
        .q_valid_out  (q_valid_out),
        .out_wr_en    (out_wr_en),
        .out_wr_addr  (out_wr_addr),
        .out_wr_data  (out_wr_data),
        .out_wr_ready (out_wr_ready)
    );

    function automatic logic [7:0] quant(input logic [31:0] v, input logic [31:0] s);
        longint p;
        p = longint'(signed'(v)) * longint'({32'd0, s});
        p = p >>> 24;
        if (p > 127)       return 8'h7F;
        else if (p < -128) return 8'h80;
        else               return p[7:0];
    endfunction

    // Accumulator memory: registered read, one-cycle latency.
    always @(posedge clk) acc_rd_data <= mem[acc_rd_addr[7:0]];

    // Quantizer model sharing the block reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            v_pipe <= '0;
            for (int i = 0; i < 3; i++) r_pipe[i] <= '0;
        end else begin
            v_pipe    <= {v_pipe[1:0], q_valid_in};
            r_pipe[0] <= quant(q_value, q_scale);
            r_pipe[1] <= r_pipe[0];
            r_pipe[2] <= r_pipe[1];
        end
    end
    assign q_result    = r_pipe[2];
    assign q_valid_out = v_pipe[2] | inj;

    // Observe reads and accepted writes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_rd_en) rd_total <= rd_total + 1;
        if (out_wr_en && out_wr_ready) begin
            wr_addr_q.push_back(out_wr_addr);
            wr_data_q.push_back(out_wr_data);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic start_job(input logic [15:0] len, input logic [31:0] sc,
                             input logic [15:0] src, input logic [15:0] dst);
        @(negedge clk);
        length = len; scale = sc; src_base = src; dst_base = dst; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, acc_rd_en, q_valid_in, out_wr_en} !== 6'b0 ||
            acc_rd_addr !== '0 || out_wr_addr !== '0 || out_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b rd_addr=%h wr_addr=%h wr_data=%h, required zeros",
                     {busy, done, err, acc_rd_en, q_valid_in, out_wr_en}, acc_rd_addr, out_wr_addr, out_wr_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_err();
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_set: err=%b, required 1", err); end
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b, required 1", err); end
    endtask

    task automatic test_single();
        int w0;
        w0 = wr_data_q.size();
        start_job(4, Q824_ONE, 0, 16);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL single_start: busy=%b err=%b, required busy=1 err=0", busy, err);
        end
        wait_done(200, "single");
        checks++;
        if (wr_data_q.size() != w0 + 1 || wr_addr_q[w0] !== 16'd16 || wr_data_q[w0] !== 32'h807F_FD05) begin
            errors++;
            $display("FAIL single_word: count=%0d addr=%h data=%h, required 1 @0010 807ffd05",
                     wr_data_q.size() - w0, wr_addr_q[w0], wr_data_q[w0]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL single_pulse: done=%b busy=%b err=%b, required 0 0 0", done, busy, err);
        end
    endtask

    task automatic test_partial();
        int w0;
        w0 = wr_data_q.size();
        start_job(6, Q824_ONE, 8, 32);
        wait_done(200, "partial");
        checks++;
        if (wr_data_q.size() != w0 + 2) begin
            errors++; $display("FAIL partial_count: got %0d words, required 2", wr_data_q.size() - w0);
        end
        checks++;
        if (wr_addr_q[w0] !== 16'd32 || wr_data_q[w0] !== 32'h0403_0201) begin
            errors++; $display("FAIL partial_w0: %h@%h, required 04030201@0020", wr_data_q[w0], wr_addr_q[w0]);
        end
        checks++;
        if (wr_addr_q[w0+1] !== 16'd33 || wr_data_q[w0+1] !== 32'h0000_0605) begin
            errors++; $display("FAIL partial_w1: %h@%h, required 00000605@0021", wr_data_q[w0+1], wr_addr_q[w0+1]);
        end
    endtask

    task automatic test_throughput();
        int w0;
        logic [31:0] exp_w;
        logic [31:0] got;
        w0 = wr_data_q.size();
        start_job(16, 32'h0080_0000, 200, 40);
        wait_done(200, "tput");
        checks++;
        if (wr_data_q.size() != w0 + 4) begin
            errors++; $display("FAIL tput_count: got %0d words, required 4", wr_data_q.size() - w0);
        end
        for (int j = 0; j < 4; j++) begin
            exp_w = {8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)};
            got   = (w0 + j < wr_data_q.size()) ? wr_data_q[w0+j] : 32'hx;
            checks++;
            if (got !== exp_w || wr_addr_q[w0+j] !== 16'(40 + j)) begin
                errors++; $display("FAIL tput_word%0d: %h@%h, required %h@%h", j, got, wr_addr_q[w0+j], exp_w, 16'(40 + j));
            end
        end
        for (int j = 1; j < 4; j++) begin
            checks++;
            if (wr_cyc_q[w0+j] - wr_cyc_q[w0+j-1] != 4) begin
                errors++; $display("FAIL tput_gap%0d: %0d cycles, required 4", j, wr_cyc_q[w0+j] - wr_cyc_q[w0+j-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int w0, r0;
        logic seen, stable;
        logic [31:0] exp_w;
        logic [31:0] got;
        @(negedge clk);
        out_wr_ready = 1'b0;
        w0 = wr_data_q.size();
        r0 = rd_total;
        start_job(64, Q824_ONE, 64, 0);
        seen = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (seen && (out_wr_en !== 1'b1 || out_wr_data !== 32'h0302_0100 || out_wr_addr !== 16'd0))
                stable = 1'b0;
            if (out_wr_en === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!(seen && stable)) begin
            errors++; $display("FAIL bp_hold: seen=%b stable=%b, required 1 1", seen, stable);
        end
        checks++;
        if (rd_total - r0 != int'(PACK + DEPTH) || acc_rd_en !== 1'b0) begin
            errors++; $display("FAIL bp_credit: reads=%0d rd_en=%b, required %0d 0", rd_total - r0, acc_rd_en, PACK + DEPTH);
        end
        checks++;
        if (wr_data_q.size() != w0) begin
            errors++; $display("FAIL bp_nowrite: %0d writes during stall, required 0", wr_data_q.size() - w0);
        end
        out_wr_ready = 1'b1;
        wait_done(1000, "bp");
        checks++;
        if (wr_data_q.size() != w0 + 16 || err !== 1'b0) begin
            errors++; $display("FAIL bp_count: %0d words err=%b, required 16 0", wr_data_q.size() - w0, err);
        end
        for (int j = 0; j < 16; j++) begin
            exp_w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
            got   = (w0 + j < wr_data_q.size()) ? wr_data_q[w0+j] : 32'hx;
            checks++;
            if (got !== exp_w || wr_addr_q[w0+j] !== 16'(j)) begin
                errors++; $display("FAIL bp_word%0d: %h@%h, required %h@%h", j, got, wr_addr_q[w0+j], exp_w, 16'(j));
            end
        end
    endtask

    task automatic test_len_zero();
        int w0, r0;
        w0 = wr_data_q.size();
        r0 = rd_total;
        start_job(0, Q824_ONE, 0, 60);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done: done=%b, required 1", done); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rd_total != r0 || wr_data_q.size() != w0) begin
            errors++; $display("FAIL zero_traffic: reads=%0d writes=%0d, required 0 0", rd_total - r0, wr_data_q.size() - w0);
        end
    endtask

    task automatic test_restart();
        int w0;
        w0 = wr_data_q.size();
        start_job(8, Q824_ONE, 160, 48);
        repeat (3) @(negedge clk);
        length = 4; src_base = 0; dst_base = 200; scale = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: busy=%b, required 1", busy); end
        wait_done(200, "restart");
        checks++;
        if (wr_data_q.size() != w0 + 2 || wr_data_q[w0] !== 32'hFCFD_FEFF || wr_addr_q[w0] !== 16'd48 ||
            wr_data_q[w0+1] !== 32'hF8F9_FAFB || wr_addr_q[w0+1] !== 16'd49) begin
            errors++;
            $display("FAIL restart_words: n=%0d %h@%h %h@%h, required 2 fcfdfeff@0030 f8f9fafb@0031",
                     wr_data_q.size() - w0, wr_data_q[w0], wr_addr_q[w0], wr_data_q[w0+1], wr_addr_q[w0+1]);
        end
    endtask

    task automatic test_reset_mid_job();
        int w0;
        start_job(64, Q824_ONE, 64, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        w0 = wr_data_q.size();
        checks++;
        if ({busy, done, err, acc_rd_en, q_valid_in, out_wr_en} !== 6'b0) begin
            errors++; $display("FAIL midreset_outputs: flags=%b, required 000000",
                               {busy, done, err, acc_rd_en, q_valid_in, out_wr_en});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start_job(4, Q824_ONE, 0, 20);
        wait_done(200, "midreset");
        repeat (12) @(negedge clk);
        checks++;
        if (wr_data_q.size() != w0 + 1 || wr_data_q[w0] !== 32'h807F_FD05 || wr_addr_q[w0] !== 16'd20) begin
            errors++;
            $display("FAIL midreset_word: n=%0d %h@%h, required 1 807ffd05@0014",
                     wr_data_q.size() - w0, wr_data_q[w0], wr_addr_q[w0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'd5;
        mem[1] = -32'sd3;
        mem[2] = 32'd200;
        mem[3] = -32'sd300;
        for (int i = 0; i < 6; i++)  mem[8 + i]   = 32'(i + 1);
        for (int i = 0; i < 64; i++) mem[64 + i]  = 32'(i);
        for (int i = 0; i < 8; i++)  mem[160 + i] = 32'(-(i + 1));
        for (int i = 0; i < 16; i++) mem[200 + i] = 32'(2 * (i + 1));

        test_reset();
        test_err();
        test_single();
        test_partial();
        test_throughput();
        test_backpressure();
        test_len_zero();
        test_restart();
        test_reset_mid_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
